periph_bus_master: RTL and testbench

// Initiator side of the peripheral cs/ack bus: bridges picorv32 native memory requests onto the bus driving simuart-class

---
 rtl/periph_bus_master_if.sv | 21 ++
 rtl/periph_bus_master.sv | 173 +++++++++++++++++
 tb/tb_periph_bus_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_master_if.sv
// Peripheral cs/ack bus between the bridge (master) and a simuart-class responder (slave).
interface periph_bus_master_if;
  logic        cs;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_val;
  logic [3:0]  bus_bytesel;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic        inter;
  logic        intack;

  modport master (
    output cs, bus_addr, bus_wr_val, bus_bytesel, intack,
    input  bus_ack, bus_data, inter
  );

  modport slave (
    input  cs, bus_addr, bus_wr_val, bus_bytesel, intack,
    output bus_ack, bus_data, inter
  );
endinterface

// File: rtl/periph_bus_master.sv
// Bridge from picorv32 native memory requests to the peripheral cs/ack bus,
// with a local ctrl/status register that also owns the inter/intack handshake.
module periph_bus_master #(
  parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter logic [7:0]  LOCAL_OFS = 8'hF0,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic                       irq,
  periph_bus_master_if.master        bus
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_DONE    = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cs_q, cs_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wval_q, wval_d;
  logic [3:0]        bsel_q, bsel_d;
  logic              intack_q, intack_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic in_window;
  logic is_local;
  logic is_write;
  logic accept;
  logic timeout_hit;
  logic intack_set;

  // Request decode and timeout compare
  always_comb begin
    in_window   = (mem_addr & ADDR_MASK) == ADDR_BASE;
    is_local    = mem_addr[7:0] == LOCAL_OFS;
    is_write    = |mem_wstrb;
    accept      = (state_q == S_IDLE) && mem_valid && in_window;
    timeout_hit = tcnt_q == TCNT_W'(TIMEOUT - 1);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; local accesses skip ACCESS and complete straight away
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = is_local ? S_DONE : S_ACCESS;
      S_ACCESS:  if (bus.bus_ack || timeout_hit) state_d = S_DONE;
      S_DONE:    state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything holds unless the state acts on it
  always_comb begin
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    cs_d       = cs_q;
    addr_d     = addr_q;
    wval_d     = wval_q;
    bsel_d     = bsel_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    intack_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_local) begin
            ready_d = 1'b1;
            if (is_write) begin
              rdata_d    = 32'h0;
              intack_set = mem_wdata[0];
              if (mem_wdata[1]) err_d = 1'b0;
            end else begin
              rdata_d = {29'b0, intack_q, irq_q, err_q};
            end
          end else begin
            cs_d   = 1'b1;
            addr_d = mem_addr & ~ADDR_MASK;
            wval_d = mem_wdata;
            bsel_d = mem_wstrb;
            tcnt_d = '0;
          end
        end
      end
      S_ACCESS: begin
        if (bus.bus_ack) begin
          cs_d    = 1'b0;
          ready_d = 1'b1;
          rdata_d = (bsel_q == 4'b0000) ? bus.bus_data : 32'h0;
        end else if (timeout_hit) begin
          cs_d    = 1'b0;
          ready_d = 1'b1;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: ;
    endcase

    // intack: set by local write, released once the responder drops inter
    if (intack_set)                 intack_d = 1'b1;
    else if (intack_q && !bus.inter) intack_d = 1'b0;
    else                            intack_d = intack_q;

    // irq masked in the same cycle intack rises
    irq_d = bus.inter & ~intack_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      cs_q     <= 1'b0;
      addr_q   <= 32'h0;
      wval_q   <= 32'h0;
      bsel_q   <= 4'b0000;
      intack_q <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      wval_q   <= wval_d;
      bsel_q   <= bsel_d;
      intack_q <= intack_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign mem_ready       = ready_q;
  assign mem_rdata       = rdata_q;
  assign irq             = irq_q;
  assign bus.cs          = cs_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_val  = wval_q;
  assign bus.bus_bytesel = bsel_q;
  assign bus.intack      = intack_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master with a registered-ack responder model.
module tb_periph_bus_master;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;
  logic        ack_en;

  int errors;
  int checks;

  periph_bus_master_if bus_if ();

  periph_bus_master dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .irq       (irq),
    .bus       (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: ack <= cs, gated so the timeout path can be exercised
  always @(posedge clk or negedge resetn) begin
    if (!resetn) bus_if.bus_ack <= 1'b0;
    else         bus_if.bus_ack <= bus_if.cs & ack_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU access; latency counted in negedges after the request negedge
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           output int lat, output logic [31:0] rdata, output int cs_cycles,
                           output logic [31:0] b_addr, output logic [31:0] b_wval,
                           output logic [3:0] b_bsel, output int extra_ready);
    bit seen_cs;
    bit done;
    lat = 0; cs_cycles = 0; extra_ready = 0; rdata = 32'hx;
    b_addr = 32'h0; b_wval = 32'h0; b_bsel = 4'h0;
    seen_cs = 0; done = 0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus_if.cs) begin
        cs_cycles++;
        if (!seen_cs) begin
          seen_cs = 1;
          b_addr = bus_if.bus_addr; b_wval = bus_if.bus_wr_val; b_bsel = bus_if.bus_bytesel;
        end
      end
      if (mem_ready) begin
        done = 1;
        rdata = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    if (!done) check("ready_wait_bound", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_ready) extra_ready++;
    end
  endtask

  int          lat, csn, xr;
  logic [31:0] rd, ba, bw;
  logic [3:0]  bb;

  initial begin
    errors = 0; checks = 0;
    resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    bus_if.bus_data = 32'h0; bus_if.inter = 1'b0; ack_en = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_cs", 32'(bus_if.cs), 32'd0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_wval", bus_if.bus_wr_val, 32'h0);
    check("rst_bsel", 32'(bus_if.bus_bytesel), 32'd0);
    check("rst_intack", 32'(bus_if.intack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Status read: cs at N+1, ack N+2, ready N+3
    bus_if.bus_data = 32'h2;
    do_access(BASE + 32'd4, 32'h0, 4'h0, lat, rd, csn, ba, bw, bb, xr);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rd, 32'h2);
    check("rd_bsel", 32'(bb), 32'd0);
    check("rd_addr", ba, 32'h4);
    check("rd_cs_cycles", 32'(csn), 32'd2);
    check("rd_single_ready", 32'(xr), 32'd0);

    // TX write
    do_access(BASE, 32'h41, 4'b0001, lat, rd, csn, ba, bw, bb, xr);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_cs_cycles", 32'(csn), 32'd2);
    check("wr_wval", bw, 32'h41);
    check("wr_bsel", 32'(bb), 32'd1);
    check("wr_rdata", rd, 32'h0);
    check("wr_single_ready", 32'(xr), 32'd0);

    // Out-of-window request is ignored
    mem_valid = 1'b1; mem_addr = 32'h3000_0004; mem_wstrb = 4'h0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready || bus_if.cs) check("oow_ignored", 32'd1, 32'd0);
    end
    check("oow_cs", 32'(bus_if.cs), 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);

    // Timeout: ack never comes; ready in cycle N+17, cs held for 16 cycles
    ack_en = 1'b0;
    do_access(BASE + 32'd8, 32'h0, 4'h0, lat, rd, csn, ba, bw, bb, xr);
    check("to_latency", 32'(lat), 32'd17);
    check("to_rdata", rd, 32'hDEAD_BEEF);
    check("to_cs_cycles", 32'(csn), 32'd16);
    ack_en = 1'b1;

    // Local status read shows sticky err, no bus traffic
    do_access(BASE + 32'hF0, 32'h0, 4'h0, lat, rd, csn, ba, bw, bb, xr);
    check("loc_rd_latency", 32'(lat), 32'd1);
    check("loc_rd_err", rd, 32'h1);
    check("loc_rd_no_cs", 32'(csn), 32'd0);
    // Write 2 clears err
    do_access(BASE + 32'hF0, 32'h2, 4'hF, lat, rd, csn, ba, bw, bb, xr);
    check("loc_wr_latency", 32'(lat), 32'd1);
    check("loc_wr_rdata", rd, 32'h0);
    do_access(BASE + 32'hF0, 32'h0, 4'h0, lat, rd, csn, ba, bw, bb, xr);
    check("loc_rd_cleared", rd, 32'h0);

    // Interrupt handshake
    bus_if.inter = 1'b1;
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    check("irq_no_intack", 32'(bus_if.intack), 32'd0);
    mem_valid = 1'b1; mem_addr = BASE + 32'hF0; mem_wdata = 32'h1; mem_wstrb = 4'hF;
    @(negedge clk);
    mem_valid = 1'b0;
    check("ack_wr_ready", 32'(mem_ready), 32'd1);
    check("intack_set", 32'(bus_if.intack), 32'd1);
    check("irq_masked", 32'(irq), 32'd0);
    @(negedge clk);
    check("intack_hold", 32'(bus_if.intack), 32'd1);
    bus_if.inter = 1'b0;
    @(negedge clk);
    check("intack_clear", 32'(bus_if.intack), 32'd0);
    check("irq_low", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);

    // Local write of intack while inter already low: exactly one-cycle pulse
    mem_valid = 1'b1; mem_addr = BASE + 32'hF0; mem_wdata = 32'h1; mem_wstrb = 4'hF;
    @(negedge clk);
    mem_valid = 1'b0;
    check("pulse_high", 32'(bus_if.intack), 32'd1);
    @(negedge clk);
    check("pulse_low", 32'(bus_if.intack), 32'd0);
    repeat (2) @(negedge clk);

    // Back-to-back reads with mem_valid held
    begin
      int          nready, rises, gap, low_run;
      logic        prev_cs;
      logic [31:0] r0, r1;
      nready = 0; rises = 0; gap = -1; low_run = 0; prev_cs = 1'b0; r0 = 32'h0; r1 = 32'h0;
      bus_if.bus_data = 32'h11;
      mem_valid = 1'b1; mem_addr = BASE + 32'd4; mem_wstrb = 4'h0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus_if.cs && !prev_cs) begin
          rises++;
          if (rises == 2) gap = low_run;
        end
        low_run = bus_if.cs ? 0 : low_run + 1;
        prev_cs = bus_if.cs;
        if (mem_ready) begin
          nready++;
          if (nready == 1) begin
            r0 = mem_rdata;
            mem_addr = BASE + 32'd8;
            bus_if.bus_data = 32'h22;
          end else begin
            r1 = mem_rdata;
            mem_valid = 1'b0;
          end
        end
      end
      mem_valid = 1'b0;
      check("b2b_ready_count", 32'(nready), 32'd2);
      check("b2b_cs_rises", 32'(rises), 32'd2);
      check("b2b_gap_ge1", 32'(gap >= 1), 32'd1);
      check("b2b_rdata0", r0, 32'h11);
      check("b2b_rdata1", r1, 32'h22);
    end

    // Reset mid-ACCESS
    begin
      int nready;
      nready = 0;
      bus_if.inter = 1'b1;
      ack_en = 1'b0;
      mem_valid = 1'b1; mem_addr = BASE + 32'd4; mem_wstrb = 4'h0;
      repeat (3) @(negedge clk);
      check("mid_cs_high", 32'(bus_if.cs), 32'd1);
      check("mid_irq_high", 32'(irq), 32'd1);
      resetn = 1'b0;
      mem_valid = 1'b0;
      #1;
      check("mid_rst_cs", 32'(bus_if.cs), 32'd0);
      check("mid_rst_ready", 32'(mem_ready), 32'd0);
      check("mid_rst_intack", 32'(bus_if.intack), 32'd0);
      check("mid_rst_irq", 32'(irq), 32'd0);
      bus_if.inter = 1'b0;
      ack_en = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_ready) nready++;
      end
      check("mid_no_ready_after", 32'(nready), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
